// File: rtl/game_pkg.sv
// Shared game definitions: shot FSM states, shot counter width and a saturating increment.
// Reused by the HUD and score blocks, so keep it free of block-specific parameters.
package game_pkg;
    localparam int SHOT_COUNT_W = 16;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FIRE,
        S_COOLDOWN,
        S_RELEASE
    } shot_state_t;

    function automatic logic [SHOT_COUNT_W-1:0] sat_inc(input logic [SHOT_COUNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction
endpackage

// File: rtl/shot_controller_if.sv
// Fire-request bus between game control, the shot controller and the missile object.
// master drives the game-side inputs; slave is the shot controller itself.
interface shot_controller_if;
    logic                           startOfFrame;
    logic                           keyFire;
    logic                           missileActive;
    logic                           gameEnable;
    logic                           shotPress;
    logic                           ready;
    logic [game_pkg::SHOT_COUNT_W-1:0] shotCount;

    modport master (
        output startOfFrame, keyFire, missileActive, gameEnable,
        input  shotPress, ready, shotCount
    );

    modport slave (
        input  startOfFrame, keyFire, missileActive, gameEnable,
        output shotPress, ready, shotCount
    );
endinterface

// File: rtl/key_debounce.sv
// Key conditioner: 2-FF synchroniser then stable-time debounce; keyDb follows after 2+DEBOUNCE_CYCLES clks.
// No backpressure: free-running level filter.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic clk,
    input  logic resetN,
    input  logic key,
    output logic keyDb
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic          db_q;
    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            db_q  <= 1'b0;
            cnt_q <= '0;
        end else begin
            sync1 <= key;
            sync2 <= sync1;
            // Any sample agreeing with the current level restarts the stability window.
            if (sync2 == db_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_LAST) begin
                db_q  <= sync2;
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign keyDb = db_q;
endmodule

// File: rtl/shot_controller.sv
// Fire-request stage: debounced key gated by missile-in-flight, frame cooldown and release-before-refire.
// shotPress is a registered one-cycle pulse; no backpressure beyond missileActive sampled in S_IDLE.
module shot_controller #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int COOLDOWN_FRAMES = 8,
    parameter int AUTO_FIRE       = 0
) (
    input logic              clk,
    input logic              resetN,
    shot_controller_if.slave bus
);
    import game_pkg::*;

    localparam int CDW = (COOLDOWN_FRAMES > 0) ? $clog2(COOLDOWN_FRAMES + 1) : 1;
    localparam logic [CDW-1:0] CD_LAST = CDW'(COOLDOWN_FRAMES);

    shot_state_t             state_q, state_d;
    logic [CDW-1:0]          cd_q, cd_d;
    logic [SHOT_COUNT_W-1:0] count_q, count_d;
    logic                    press_q;
    logic                    out_en_q;
    logic                    key_db;

    key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key_debounce (
        .clk   (clk),
        .resetN(resetN),
        .key   (bus.keyFire),
        .keyDb (key_db)
    );

    always_comb begin
        state_d = state_q;
        cd_d    = cd_q;
        case (state_q)
            S_IDLE: begin
                if (bus.gameEnable && key_db && !bus.missileActive) state_d = S_FIRE;
            end
            S_FIRE: begin
                cd_d    = '0;
                state_d = (COOLDOWN_FRAMES > 0) ? S_COOLDOWN : S_RELEASE;
            end
            S_COOLDOWN: begin
                if (bus.startOfFrame) begin
                    cd_d = cd_q + 1'b1;
                    if (cd_d == CD_LAST) state_d = S_RELEASE;
                end
            end
            S_RELEASE: begin
                if (AUTO_FIRE != 0 || !key_db) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        // Disabling gameplay aborts any shot sequence, including a pending cooldown.
        if (!bus.gameEnable) begin
            state_d = S_IDLE;
            cd_d    = '0;
        end
        count_d = (state_d == S_FIRE) ? sat_inc(count_q) : count_q;
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q  <= S_IDLE;
            cd_q     <= '0;
            count_q  <= '0;
            press_q  <= 1'b0;
            out_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cd_q     <= cd_d;
            count_q  <= count_d;
            press_q  <= (state_d == S_FIRE);
            out_en_q <= 1'b1;
        end
    end

    // out_en_q keeps the HUD indicator low while reset is asserted, whatever the inputs do.
    assign bus.shotPress = press_q;
    assign bus.ready     = out_en_q && (state_q == S_IDLE) && bus.gameEnable && !bus.missileActive;
    assign bus.shotCount = count_q;
endmodule
